// File: rtl/program_loader.sv
// program_loader: fills IMem/DMem from a valid/ready host stream while holding the core in reset,
// then releases the core and waits for it to finish.
module program_loader #(
  parameter int INST_W  = 16,
  parameter int IADDR_W = 4,
  parameter int DATA_W  = 16,
  parameter int DADDR_W = 4,
  parameter int HOST_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [IADDR_W:0]   inst_count,
  input  logic [DADDR_W:0]   data_count,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [HOST_W-1:0]  s_data,
  output logic               imem_we,
  output logic [IADDR_W-1:0] imem_waddr,
  output logic [INST_W-1:0]  imem_wdata,
  input  logic [DADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0]  core_wdata,
  input  logic               core_we,
  output logic [DADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0]  dmem_wdata,
  output logic               dmem_we,
  input  logic               core_done,
  output logic               core_reset,
  output logic               busy,
  output logic               done
);
  typedef enum logic [2:0] {IDLE, LOAD_I, LOAD_D, FLUSH, RELEASE, RUN, DONE} state_t;
  localparam logic [IADDR_W:0] I_MAX = {1'b1, {IADDR_W{1'b0}}};
  localparam logic [DADDR_W:0] D_MAX = {1'b1, {DADDR_W{1'b0}}};
  localparam logic [IADDR_W:0] I_ONE = {{IADDR_W{1'b0}}, 1'b1};
  localparam logic [DADDR_W:0] D_ONE = {{DADDR_W{1'b0}}, 1'b1};
  state_t state, next;
  logic [IADDR_W:0] ni, ki;
  logic [DADDR_W:0] nd, kd;
  logic [DADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic ld_we, xfer, start_ok, last_i, last_d, run, unused;
  assign unused   = ^s_data;
  assign run      = state == RUN;
  assign s_ready  = state == LOAD_I || state == LOAD_D;
  assign xfer     = s_valid && s_ready;
  assign start_ok = start && (state == IDLE || state == DONE);
  assign last_i   = ki + I_ONE == ni;
  assign last_d   = kd + D_ONE == nd;
  assign core_reset = !run;
  assign busy     = state != IDLE && state != DONE;
  assign done     = state == DONE;
  assign dmem_addr  = run ? core_addr : ld_addr;
  assign dmem_wdata = run ? core_wdata : ld_wdata;
  assign dmem_we    = run ? core_we : ld_we;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE, DONE: if (start) next = inst_count != '0 ? LOAD_I : data_count != '0 ? LOAD_D : FLUSH;
      LOAD_I:     if (xfer && last_i) next = nd != '0 ? LOAD_D : FLUSH;
      LOAD_D:     if (xfer && last_d) next = FLUSH;
      FLUSH:      next = RELEASE;
      RELEASE:    next = RUN;
      RUN:        if (core_done) next = DONE;
      default:    next = IDLE;
    endcase
  end
  // Counts are clamped to memory depth so the word index never wraps.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ni <= '0;
      nd <= '0;
      ki <= '0;
      kd <= '0;
      imem_we <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
      ld_we <= 1'b0;
      ld_addr <= '0;
      ld_wdata <= '0;
    end else begin
      imem_we <= 1'b0;
      ld_we <= 1'b0;
      if (start_ok) begin
        ni <= inst_count > I_MAX ? I_MAX : inst_count;
        nd <= data_count > D_MAX ? D_MAX : data_count;
        ki <= '0;
        kd <= '0;
      end
      if (xfer && state == LOAD_I) begin
        imem_we <= 1'b1;
        imem_waddr <= ki[IADDR_W-1:0];
        imem_wdata <= s_data[INST_W-1:0];
        ki <= ki + I_ONE;
      end
      if (xfer && state == LOAD_D) begin
        ld_we <= 1'b1;
        ld_addr <= kd[DADDR_W-1:0];
        ld_wdata <= s_data[DATA_W-1:0];
        kd <= kd + D_ONE;
      end
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: random host streams checked against memory images and handshake/reset timing.
module tb_program_loader;
  localparam int IW = 16, IAW = 4, DW = 16, DAW = 4, DEPTH = 16;
  localparam logic [15:0] SENT = 16'hDEAD;
  logic clk = 0, reset = 1, start = 0, s_valid = 0, s_ready;
  logic [IAW:0] inst_count = '0;
  logic [DAW:0] data_count = '0;
  logic [31:0] s_data = '0;
  logic imem_we, dmem_we, core_we = 0, core_done = 0, core_reset, busy, done;
  logic [IAW-1:0] imem_waddr;
  logic [IW-1:0] imem_wdata;
  logic [DAW-1:0] core_addr = '0, dmem_addr;
  logic [DW-1:0] core_wdata = '0, dmem_wdata;
  logic [IW-1:0] imem_m [DEPTH];
  logic [DW-1:0] dmem_m [DEPTH];
  logic [31:0] hw [64];
  logic clr = 0;
  int n_iwe = 0, n_dwe = 0, n_vec = 0, n_err = 0;

  program_loader #(.INST_W(IW), .IADDR_W(IAW), .DATA_W(DW), .DADDR_W(DAW), .HOST_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .inst_count(inst_count), .data_count(data_count),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .core_addr(core_addr), .core_wdata(core_wdata), .core_we(core_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we),
    .core_done(core_done), .core_reset(core_reset), .busy(busy), .done(done));

  always #5 clk = ~clk;

  // Behavioural IMem/DMem attached to the loader's write ports.
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        imem_m[i] <= SENT;
        dmem_m[i] <= SENT;
      end
    end else begin
      if (imem_we) imem_m[imem_waddr] <= imem_wdata;
      if (dmem_we) dmem_m[dmem_addr] <= dmem_wdata;
    end
    if (imem_we) n_iwe <= n_iwe + 1;
    if (dmem_we) n_dwe <= n_dwe + 1;
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem;
    clr = 1;
    tick;
    clr = 0;
  endtask

  task automatic wait_run(int exp_edges, string tag);
    int n = 0;
    while (core_reset && n < 10) begin
      tick;
      n++;
    end
    chk(tag, n, exp_edges);
  endtask

  task automatic end_run;
    core_done = 1;
    tick;
    core_done = 0;
    chk("done", done, 1);
    chk("done_core_reset", core_reset, 1);
    chk("done_busy", busy, 0);
  endtask

  // mode 0: back-to-back, 1: valid toggles, 2: random valid. glitch pulses start mid-load.
  task automatic load(int ni, int nd, int mode, bit glitch);
    int nis, nds, tot, idx, cyc, iw0, dw0;
    bit v, glitched;
    nis = ni > DEPTH ? DEPTH : ni;
    nds = nd > DEPTH ? DEPTH : nd;
    tot = nis + nds;
    for (int i = 0; i < tot; i++) hw[i] = $urandom;
    clear_mem;
    iw0 = n_iwe;
    dw0 = n_dwe;
    inst_count = ni[IAW:0];
    data_count = nd[DAW:0];
    start = 1;
    tick;
    start = 0;
    idx = 0;
    cyc = 0;
    glitched = 0;
    while (idx < tot && cyc < 400) begin
      v = mode == 0 ? 1'b1 : mode == 1 ? cyc[0] == 1'b0 : 1'($urandom_range(0, 1));
      s_valid = v;
      s_data = v ? hw[idx] : $urandom;
      if (glitch && idx == 1 && !glitched) begin
        start = 1;
        inst_count = '0;
        data_count = '0;
        glitched = 1;
      end
      chk("s_ready", s_ready, 1);
      tick;
      start = 0;
      inst_count = ni[IAW:0];
      data_count = nd[DAW:0];
      if (v) idx++;
      cyc++;
    end
    s_valid = 0;
    chk("load_words", idx, tot);
    chk("flush_ready", s_ready, 0);
    chk("flush_busy", busy, 1);
    wait_run(2, "release_latency");
    chk("run_busy", busy, 1);
    for (int i = 0; i < nis; i++) chk("imem", imem_m[i], hw[i][IW-1:0]);
    for (int i = 0; i < nds; i++) chk("dmem", dmem_m[i], hw[nis+i][DW-1:0]);
    chk("imem_we_count", n_iwe - iw0, nis);
    chk("dmem_we_count", n_dwe - dw0, nds);
  endtask

  initial begin
    #3 reset = 0;
    tick;
    chk("rst_core_reset", core_reset, 1);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_imem_we", imem_we, 0);
    chk("rst_dmem_we", dmem_we, 0);
    chk("rst_dmem_addr", dmem_addr, 0);
    chk("rst_imem_waddr", imem_waddr, 0);
    reset = 1;
    tick;
    load(3, 2, 0, 0);
    end_run;
    load(3, 2, 1, 0);
    end_run;
    load(0, 0, 0, 0);
    end_run;
    clear_mem;
    inst_count = 2;
    data_count = 4;
    start = 1;
    tick;
    start = 0;
    s_valid = 1;
    for (int i = 0; i < 3; i++) begin
      s_data = $urandom;
      tick;
    end
    s_valid = 0;
    chk("abort_pre_we", dmem_we, 1);
    reset = 0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_core_reset", core_reset, 1);
    chk("abort_dmem_we", dmem_we, 0);
    chk("abort_s_ready", s_ready, 0);
    reset = 1;
    tick;
    tick;
    chk("abort_no_write", dmem_m[0], SENT);
    load(2, 4, 2, 0);
    end_run;
    load(1, 1, 0, 0);
    core_addr = 5;
    core_wdata = 42;
    core_we = 1;
    #1;
    chk("run_mux_we", dmem_we, 1);
    chk("run_mux_addr", dmem_addr, 5);
    chk("run_mux_wdata", dmem_wdata, 42);
    tick;
    core_we = 0;
    chk("core_write", dmem_m[5], 42);
    end_run;
    core_addr = 6;
    core_wdata = 7;
    core_we = 1;
    #1;
    chk("done_mux_we", dmem_we, 0);
    tick;
    core_we = 0;
    chk("done_no_write", dmem_m[6], SENT);
    load(3, 2, 0, 1);
    end_run;
    repeat (6) begin
      load(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)), 2, 0);
      end_run;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
